// File: rtl/elevator_pkg.sv
// Shared types, default sizes and helpers for the elevator call scheduler.
package elevator_pkg;

    localparam int unsigned N_FLOORS_DEF       = 5;
    localparam int unsigned FLOOR_W_DEF        = 3;
    localparam int unsigned DWELL_CYCLES_DEF   = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    // Widest call/req vector the onehot helper can produce.
    localparam int unsigned MAX_FLOORS = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DWELL    = 2'd2
    } sched_state_t;

    // One-hot mask for a floor index; out-of-range indices give an empty mask.
    function automatic logic [MAX_FLOORS-1:0] onehot(input logic [31:0] idx);
        logic [MAX_FLOORS-1:0] mask;
        mask = '0;
        if (idx < 32'(MAX_FLOORS)) begin
            mask[idx[4:0]] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/floor_picker.sv
// SCAN target selection: serve the current floor first, otherwise the nearest
// pending floor in the travel direction, otherwise the nearest one behind
// (which reverses the direction when dispatched).
module floor_picker
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS = N_FLOORS_DEF,
    parameter int unsigned FLOOR_W  = FLOOR_W_DEF
) (
    input  logic [N_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]  cur_floor_i,
    input  logic                dir_up_i,
    output logic [FLOOR_W-1:0]  tgt_o_c,
    output logic                tgt_valid_o_c,
    output logic                flip_dir_o_c
);

    logic               here_found;
    logic               above_found;
    logic               below_found;
    logic [FLOOR_W-1:0] above_idx;
    logic [FLOOR_W-1:0] below_idx;
    logic [31:0]        cur_ext;

    assign cur_ext = 32'(cur_floor_i);

    // Scan all floors: lowest pending index above the car, highest below it.
    // An out-of-range car position never matches, so it only sees floors below.
    always_comb begin
        here_found  = 1'b0;
        above_found = 1'b0;
        below_found = 1'b0;
        above_idx   = '0;
        below_idx   = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (pending_i[i]) begin
                if (i == cur_ext) begin
                    here_found = 1'b1;
                end else if (i > cur_ext) begin
                    if (!above_found) begin
                        above_found = 1'b1;
                        above_idx   = FLOOR_W'(i);
                    end
                end else begin
                    below_found = 1'b1;
                    below_idx   = FLOOR_W'(i);
                end
            end
        end
    end

    // Apply direction preference and report whether the pick reverses travel.
    always_comb begin
        tgt_o_c       = '0;
        tgt_valid_o_c = 1'b0;
        flip_dir_o_c  = 1'b0;
        if (here_found) begin
            tgt_o_c       = cur_floor_i;
            tgt_valid_o_c = 1'b1;
        end else if (dir_up_i) begin
            if (above_found) begin
                tgt_o_c       = above_idx;
                tgt_valid_o_c = 1'b1;
            end else if (below_found) begin
                tgt_o_c       = below_idx;
                tgt_valid_o_c = 1'b1;
                flip_dir_o_c  = 1'b1;
            end
        end else begin
            if (below_found) begin
                tgt_o_c       = below_idx;
                tgt_valid_o_c = 1'b1;
            end else if (above_found) begin
                tgt_o_c       = above_idx;
                tgt_valid_o_c = 1'b1;
                flip_dir_o_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Call-request scheduler in front of the elevator controller: latches calls,
// dispatches one SCAN target at a time as a stable one-hot request, holds the
// door dwell, and raises a sticky fault when a dispatch never arrives.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS       = N_FLOORS_DEF,
    parameter int unsigned FLOOR_W        = FLOOR_W_DEF,
    parameter int unsigned DWELL_CYCLES   = DWELL_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                door_open,
    input  logic                busy,
    output logic [N_FLOORS-1:0] req_out,
    output logic [N_FLOORS-1:0] pending,
    output logic                dir_up,
    output logic                fault
);

    // Dwell counts DWELL_CYCLES-1 down to 0; timeout counts 0 up to TIMEOUT_CYCLES-1.
    localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    sched_state_t        state_q,   state_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [N_FLOORS-1:0] req_q,     req_d;
    logic                dir_up_q,  dir_up_d;
    logic                fault_q,   fault_d;
    logic [DWELL_W-1:0]  dwell_q,   dwell_d;
    logic [TMO_W-1:0]    tmo_q,     tmo_d;

    logic [N_FLOORS-1:0] clr_mask;
    logic [FLOOR_W-1:0]  pick_tgt_c;
    logic                pick_valid_c;
    logic                pick_flip_c;

    floor_picker #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_picker (
        .pending_i     (pending_q),
        .cur_floor_i   (current_floor),
        .dir_up_i      (dir_up_q),
        .tgt_o_c       (pick_tgt_c),
        .tgt_valid_o_c (pick_valid_c),
        .flip_dir_o_c  (pick_flip_c)
    );

    // Door opening serves the floor the car is at; invalid positions clear nothing.
    always_comb begin
        clr_mask = '0;
        if (door_open) begin
            for (int unsigned i = 0; i < N_FLOORS; i++) begin
                if (32'(current_floor) == i) begin
                    clr_mask[i] = 1'b1;
                end
            end
        end
    end

    // Calls latch in every state; a same-cycle clear overrides a new call.
    assign pending_d = (pending_q | call_btn) & ~clr_mask;

    // Scheduler next state: dispatch, hold the request, dwell, time out.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        dir_up_d = dir_up_q;
        fault_d  = fault_q;
        dwell_d  = dwell_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            IDLE: begin
                req_d = '0;
                if (pick_valid_c && !busy) begin
                    state_d = DISPATCH;
                    req_d   = N_FLOORS'(onehot(32'(pick_tgt_c)));
                    tmo_d   = '0;
                    if (pick_flip_c) begin
                        dir_up_d = ~dir_up_q;
                    end
                end
            end
            DISPATCH: begin
                if (door_open) begin
                    state_d = DWELL;
                    req_d   = '0;
                    dwell_d = DWELL_W'(DWELL_CYCLES - 1);
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    req_d   = '0;
                    fault_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DWELL: begin
                req_d = '0;
                if (dwell_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
            end
        endcase
    end

    // State and output registers; reset drops the request and forgets all calls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            req_q     <= '0;
            dir_up_q  <= 1'b1;
            fault_q   <= 1'b0;
            dwell_q   <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            dir_up_q  <= dir_up_d;
            fault_q   <= fault_d;
            dwell_q   <= dwell_d;
            tmo_q     <= tmo_d;
        end
    end

    assign req_out = req_q;
    assign pending = pending_q;
    assign dir_up  = dir_up_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: a behavioural scheduler model predicts every req_out change
// (value and cycle) into a queue, a monitor pops and compares as the DUT changes.
module tb_elevator_scheduler;

    localparam int unsigned NF  = 5;
    localparam int unsigned FW  = 3;
    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 255;

    logic          clk;
    logic          reset_n;
    logic [NF-1:0] call_btn;
    logic [FW-1:0] current_floor;
    logic          door_open;
    logic          busy;
    logic [NF-1:0] req_out;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          fault;

    elevator_scheduler #(
        .N_FLOORS       (NF),
        .FLOOR_W        (FW),
        .DWELL_CYCLES   (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .call_btn      (call_btn),
        .current_floor (current_floor),
        .door_open     (door_open),
        .busy          (busy),
        .req_out       (req_out),
        .pending       (pending),
        .dir_up        (dir_up),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_FREE, M_MOVE, M_BOARD} mphase_t;
    typedef struct {
        int            t;
        logic [NF-1:0] v;
    } ev_t;

    ev_t           exp_q[$];
    logic [NF-1:0] m_pend    = '0;
    bit            m_dir     = 1'b1;
    bit            m_fault   = 1'b0;
    mphase_t       m_ph      = M_FREE;
    int            m_left    = 0;
    int            m_elapsed = 0;
    int            m_tgt;
    bit            m_flip;
    logic [NF-1:0] m_nxt;
    logic [NF-1:0] m_oh;

    // Where the car should head next given the calls, its floor and its direction.
    function automatic int model_pick(input logic [NF-1:0] p, input int cf, input bit dir,
                                      output bit flip);
        int nfi;
        int up;
        int dn;
        nfi  = NF;
        flip = 1'b0;
        up   = -1;
        dn   = -1;
        if (p == '0) return -1;
        if (cf < nfi && p[cf]) return cf;
        for (int d = 1; d < 8; d++) begin
            if (up < 0 && cf + d < nfi && p[cf + d]) up = cf + d;
            if (dn < 0 && cf - d >= 0 && cf - d < nfi && p[cf - d]) dn = cf - d;
        end
        if (dir) begin
            if (up >= 0) return up;
            flip = 1'b1;
            return dn;
        end
        if (dn >= 0) return dn;
        flip = 1'b1;
        return up;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend  = '0;
            m_dir   = 1'b1;
            m_fault = 1'b0;
            m_ph    = M_FREE;
            exp_q.delete();
        end else begin
            cyc++;
            m_tgt = model_pick(m_pend, int'(current_floor), m_dir, m_flip);
            m_nxt = m_pend | call_btn;
            if (door_open && current_floor < NF) m_nxt[current_floor] = 1'b0;
            case (m_ph)
                M_FREE: begin
                    if (m_tgt >= 0 && !busy) begin
                        m_ph      = M_MOVE;
                        m_elapsed = 0;
                        if (m_flip) m_dir = !m_dir;
                        m_oh        = '0;
                        m_oh[m_tgt] = 1'b1;
                        exp_q.push_back('{t: cyc, v: m_oh});
                    end
                end
                M_MOVE: begin
                    if (door_open) begin
                        m_ph   = M_BOARD;
                        m_left = DW;
                        exp_q.push_back('{t: cyc, v: '0});
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == TMO) begin
                            m_fault = 1'b1;
                            m_ph    = M_FREE;
                            exp_q.push_back('{t: cyc, v: '0});
                        end
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_ph = M_FREE;
                end
            endcase
            m_pend = m_nxt;
        end
    end

    // ---------------- monitor ----------------
    logic [NF-1:0] last_req = '0;
    ev_t           ev;

    always @(negedge clk) begin
        if (!reset_n) begin
            last_req = '0;
        end else begin
            check("pending", 32'(pending), 32'(m_pend));
            check("dir_up", 32'(dir_up), 32'(m_dir));
            check("fault", 32'(fault), 32'(m_fault));
            if (req_out !== last_req) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL req_change @cycle %0d: req_out became 0x%0h, expected no change",
                             cyc, req_out);
                end else begin
                    ev = exp_q.pop_front();
                    check("req_value", 32'(req_out), 32'(ev.v));
                    check("req_cycle", 32'(cyc), 32'(ev.t));
                end
                last_req = req_out;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit moving     = 1'b0;
    int travel     = 0;
    bit doors_en   = 1'b1;
    bit rand_calls = 1'b1;

    function automatic int floor_of(input logic [NF-1:0] v);
        for (int i = 0; i < NF; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One cycle of a simple car: travel a few cycles, then arrive and open the door.
    task automatic emu_step();
        @(negedge clk);
        door_open = 1'b0;
        call_btn  = (rand_calls && $urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
        if (req_out == '0) moving = 1'b0;
        if (req_out != '0 && !moving) begin
            moving = 1'b1;
            travel = $urandom_range(1, 8);
            busy   = 1'b1;
        end
        if (moving) begin
            if (travel > 0) begin
                travel--;
                if ($urandom_range(0, 2) == 0) current_floor = FW'($urandom_range(0, NF - 1));
            end else if (doors_en) begin
                current_floor = FW'(floor_of(req_out));
                door_open     = 1'b1;
                moving        = 1'b0;
                busy          = 1'b0;
            end
        end else begin
            busy = ($urandom_range(0, 7) == 0);
            if (doors_en && $urandom_range(0, 15) == 0) door_open = 1'b1;
            if ($urandom_range(0, 11) == 0) current_floor = FW'($urandom_range(0, 7));
        end
    endtask

    task automatic wait_req(input int max, input string name);
        int n;
        n = 0;
        while (req_out == '0 && n < max) begin
            @(negedge clk);
            call_btn  = '0;
            door_open = 1'b0;
            n++;
        end
        check(name, 32'(req_out != '0), 32'd1);
    endtask

    task automatic serve();
        current_floor = FW'(floor_of(req_out));
        door_open     = 1'b1;
        @(negedge clk);
        door_open = 1'b0;
        call_btn  = '0;
    endtask

    initial begin
        reset_n       = 1'b0;
        call_btn      = '0;
        current_floor = '0;
        door_open     = 1'b0;
        busy          = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_out", 32'(req_out), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_dir_up", 32'(dir_up), 32'd1);
        check("rst_fault", 32'(fault), 32'd0);
        #2 reset_n = 1'b1;

        // Car at floor 0, one call for floor 3, with a repeat call as the door opens.
        @(negedge clk);
        call_btn = 5'b01000;
        @(negedge clk);
        call_btn = '0;
        @(negedge clk);
        check("t2_req_latency", 32'(req_out), 32'b01000);
        repeat (3) begin
            @(negedge clk);
            check("t2_req_held", 32'(req_out), 32'b01000);
        end
        current_floor = 3'd3;
        door_open     = 1'b1;
        call_btn      = 5'b01000;
        @(negedge clk);
        door_open = 1'b0;
        call_btn  = '0;
        check("t5_clear_wins", 32'(pending), 32'd0);
        repeat (8) begin
            check("t2_dwell_req", 32'(req_out), 32'd0);
            @(negedge clk);
        end

        // From floor 2 going up with calls at 4 and 0.
        current_floor = 3'd2;
        call_btn      = 5'b10001;
        @(negedge clk);
        call_btn = '0;
        wait_req(40, "t3_first_seen");
        check("t3_first_tgt", 32'(req_out), 32'b10000);
        check("t3_first_dir", 32'(dir_up), 32'd1);
        serve();
        wait_req(40, "t3_second_seen");
        check("t3_second_tgt", 32'(req_out), 32'b00001);
        check("t3_second_dir", 32'(dir_up), 32'd0);
        serve();

        // Floor 1 heading to 3, new call for 2 while moving.
        current_floor = 3'd1;
        call_btn      = 5'b01000;
        @(negedge clk);
        call_btn = '0;
        wait_req(40, "t4_first_seen");
        check("t4_first_tgt", 32'(req_out), 32'b01000);
        check("t4_first_dir", 32'(dir_up), 32'd1);
        call_btn = 5'b00100;
        repeat (3) begin
            @(negedge clk);
            call_btn = '0;
            check("t4_req_stable", 32'(req_out), 32'b01000);
        end
        serve();
        wait_req(40, "t4_second_seen");
        check("t4_second_tgt", 32'(req_out), 32'b00100);
        check("t4_second_dir", 32'(dir_up), 32'd0);
        serve();

        // Randomised traffic.
        moving = 1'b0;
        repeat (3000) emu_step();

        // Car never arrives: dispatch must time out and fault must stick.
        doors_en = 1'b0;
        emu_step();
        call_btn = call_btn | 5'b00010;
        for (int i = 0; i < 400 && !fault; i++) emu_step();
        check("t6_fault_set", 32'(fault), 32'd1);
        check("t6_req_dropped", 32'(req_out), 32'd0);
        repeat (300) emu_step();
        doors_en = 1'b1;
        repeat (600) emu_step();
        check("t6_fault_sticky", 32'(fault), 32'd1);

        // Asynchronous reset while a request is out.
        for (int i = 0; i < 200 && req_out == '0; i++) emu_step();
        check("t1_req_before_reset", 32'(req_out != '0), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t1_req_out", 32'(req_out), 32'd0);
        check("t1_pending", 32'(pending), 32'd0);
        check("t1_dir_up", 32'(dir_up), 32'd1);
        check("t1_fault", 32'(fault), 32'd0);
        moving = 1'b0;
        @(negedge clk);
        call_btn  = '0;
        door_open = 1'b0;
        busy      = 1'b0;
        #2 reset_n = 1'b1;
        repeat (400) emu_step();

        @(negedge clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
